// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions for the byte-serial instruction fetch path.
package fetch_sequencer_pkg;

  // Fetch sequencer states: two reset-vector reads, then opcode/operand bytes, then hold
  typedef enum logic [2:0] {
    RST_LO = 3'd0,
    RST_HI = 3'd1,
    OPC    = 3'd2,
    OP1    = 3'd3,
    OP2    = 3'd4,
    HOLD   = 3'd5
  } fetch_state_e;

  // Low byte of the reset vector; the high byte follows at RESET_VEC+1
  localparam logic [15:0] RESET_VEC = 16'hFFFC;

  // Instruction length encodings
  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  // Assembled instruction as presented to the decoder
  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  len;
  } inst_t;

endpackage

// File: rtl/fetch_sequencer_len_decode.sv
// Combinational instruction length decode from the opcode byte (aaabbbcc).
// Kept standalone so the decoder can reuse the same table.
module inst_len_decode
  import fetch_sequencer_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len
);

  logic [2:0] aaa;
  logic [2:0] bbb;
  logic [1:0] cc;

  assign aaa = opcode[7:5];
  assign bbb = opcode[4:2];
  assign cc  = opcode[1:0];

  // Length table by opcode group (cc), then addressing mode (bbb)
  always_comb begin
    len = LEN_1;
    unique case (cc)
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = LEN_3;
        else                                                 len = LEN_2;
      end
      2'b10: begin
        case (bbb)
          3'b000, 3'b001, 3'b101: len = LEN_2;
          3'b011, 3'b111:         len = LEN_3;
          default:                len = LEN_1;
        endcase
      end
      2'b00: begin
        case (bbb)
          3'b000: begin
            // JSR carries a full address; other control ops are implied or immediate
            if (aaa == 3'b001) len = LEN_3;
            else if (aaa[2])   len = LEN_2;
            else               len = LEN_1;
          end
          3'b001, 3'b100, 3'b101: len = LEN_2;
          3'b011, 3'b111:         len = LEN_3;
          default:                len = LEN_1;
        endcase
      end
      default: len = LEN_1;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: reads the reset vector, then assembles
// 1..3 byte instructions one memory byte at a time and holds each until the
// decoder accepts it. A redirect from execute abandons the current fetch.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [7:0]  inst_opcode,
  output logic [7:0]  inst_op1,
  output logic [7:0]  inst_op2,
  output logic [1:0]  inst_len,
  output logic [15:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         mem_req_q, mem_req_d;
  logic [15:0]  mem_addr_q, mem_addr_d;
  inst_t        inst_q, inst_d;

  logic         ack;
  logic         redirect_take;
  logic         accept;
  logic [1:0]   dec_len;
  logic [15:0]  next_seq_pc;

  // Length of the byte currently returning from memory (only used in OPC)
  inst_len_decode u_len_decode (
    .opcode (mem_rdata),
    .len    (dec_len)
  );

  assign ack           = mem_req_q & mem_ack;
  assign redirect_take = redirect_valid & (state_q inside {OPC, OP1, OP2, HOLD});
  assign accept        = (state_q == HOLD) & inst_ready;
  assign next_seq_pc   = inst_q.pc + {14'd0, inst_q.len};

  // Next-state, request and instruction assembly
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    inst_d     = inst_q;

    if (redirect_take) begin
      // Redirect wins over any ack or handshake; the request idles one cycle
      // so the dropped byte cannot be mistaken for the new target's data.
      pc_d       = redirect_pc;
      state_d    = OPC;
      mem_req_d  = 1'b0;
      mem_addr_d = redirect_pc;
    end else begin
      unique case (state_q)
        RST_LO: begin
          if (!mem_req_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = RESET_VEC;
          end else if (ack) begin
            pc_d[7:0]  = mem_rdata;
            state_d    = RST_HI;
            mem_addr_d = RESET_VEC + 16'd1;
          end
        end
        RST_HI: begin
          if (ack) begin
            pc_d[15:8] = mem_rdata;
            state_d    = OPC;
            mem_addr_d = {mem_rdata, pc_q[7:0]};
          end
        end
        OPC: begin
          if (!mem_req_q) begin
            // Only reached after a redirect's idle cycle
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end else if (ack) begin
            inst_d.pc     = pc_q;
            inst_d.opcode = mem_rdata;
            inst_d.op1    = 8'h00;
            inst_d.op2    = 8'h00;
            inst_d.len    = dec_len;
            if (dec_len == LEN_1) begin
              state_d   = HOLD;
              mem_req_d = 1'b0;
            end else begin
              state_d    = OP1;
              mem_addr_d = pc_q + 16'd1;
            end
          end
        end
        OP1: begin
          if (ack) begin
            inst_d.op1 = mem_rdata;
            if (inst_q.len == LEN_3) begin
              state_d    = OP2;
              mem_addr_d = inst_q.pc + 16'd2;
            end else begin
              state_d   = HOLD;
              mem_req_d = 1'b0;
            end
          end
        end
        OP2: begin
          if (ack) begin
            inst_d.op2 = mem_rdata;
            state_d    = HOLD;
            mem_req_d  = 1'b0;
          end
        end
        HOLD: begin
          // No prefetch while holding; next opcode request starts on accept
          if (accept) begin
            pc_d       = next_seq_pc;
            state_d    = OPC;
            mem_req_d  = 1'b1;
            mem_addr_d = next_seq_pc;
          end
        end
        default: begin
          state_d   = RST_LO;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  // State, request and instruction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_LO;
      pc_q       <= 16'h0000;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 16'h0000;
      inst_q     <= '{pc: 16'h0000, opcode: 8'h00, op1: 8'h00, op2: 8'h00, len: LEN_1};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      inst_q     <= inst_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign inst_valid  = (state_q == HOLD);
  assign inst_opcode = inst_q.opcode;
  assign inst_op1    = inst_q.op1;
  assign inst_op2    = inst_q.op2;
  assign inst_len    = inst_q.len;
  assign inst_pc     = inst_q.pc;

  // A live request only changes or drops after its ack or a redirect
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_q && !mem_ack && !redirect_take) |=> (mem_req_q && $stable(mem_addr_q)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: byte memory with programmable wait
// states and a reference model that walks the program from its own pc.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [7:0]  inst_opcode, inst_op1, inst_op2;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  logic [7:0]  mem [0:65535];
  int          waits = 0;
  int          wcnt = 0;
  int          asserts = 0;
  int          fails = 0;
  logic [15:0] mpc;
  logic [41:0] act;

  assign act = {inst_pc, inst_opcode, inst_op1, inst_op2, inst_len};

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_opcode    (inst_opcode),
    .inst_op1       (inst_op1),
    .inst_op2       (inst_op2),
    .inst_len       (inst_len),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory: acks a request after 'waits' idle cycles, data valid with the ack
  always @(negedge clk) begin
    if (mem_ack) wcnt = 0;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wcnt >= waits) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Instruction length straight from the opcode-field rules
  function automatic int ref_len(input logic [7:0] op);
    int a, b, c;
    a = int'(op[7:5]); b = int'(op[4:2]); c = int'(op[1:0]);
    if (c == 3) return 1;
    if (c == 1) return (b == 3 || b == 6 || b == 7) ? 3 : 2;
    if (b == 3 || b == 7) return 3;
    if (c == 2) return (b == 0 || b == 1 || b == 5) ? 2 : 1;
    if (b == 0) return (a == 1) ? 3 : (a >= 4) ? 2 : 1;
    return (b == 1 || b == 4 || b == 5) ? 2 : 1;
  endfunction

  // Expected {pc, opcode, op1, op2, len} for an instruction at pc
  function automatic logic [41:0] exp_inst(input logic [15:0] pc);
    int l;
    logic [15:0] p1, p2;
    logic [7:0]  o1, o2;
    l  = ref_len(mem[pc]);
    p1 = pc + 16'd1;
    p2 = pc + 16'd2;
    o1 = (l >= 2) ? mem[p1] : 8'h00;
    o2 = (l == 3) ? mem[p2] : 8'h00;
    return {pc, mem[pc], o1, o2, 2'(l)};
  endfunction

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (inst_valid) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_addr(input logic [15:0] a, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mem_req && mem_addr == a) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  task automatic do_redirect(input logic [15:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic do_accept;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  task automatic check_vector_fetch(input string tag);
    logic [15:0] seq [3];
    seq[0] = 16'hFFFC; seq[1] = 16'hFFFD; seq[2] = 16'h8000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      asserts++;
      if (!(mem_req === 1'b1 && mem_addr === seq[i])) begin
        fails++;
        $display("FAIL %s_addr%0d: got req=%b addr=%h expected req=1 addr=%h", tag, i, mem_req, mem_addr, seq[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({mem_req, mem_addr} !== {1'b0, 16'h0000}) begin
      fails++; $display("FAIL reset_mem: got req=%b addr=%h expected 0/0000", mem_req, mem_addr);
    end
    asserts++;
    if (inst_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b expected 0", inst_valid);
    end
    asserts++;
    if (act !== {16'h0000, 8'h00, 8'h00, 8'h00, 2'd1}) begin
      fails++; $display("FAIL reset_inst: got %h expected %h", act, {16'h0000, 8'h00, 8'h00, 8'h00, 2'd1});
    end
    rst_n = 1'b1;
    check_vector_fetch("reset");
    mpc = 16'h8000;
  endtask

  task automatic test_abs3;
    int cyc;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (inst_valid) break;
    end
    asserts++;
    if (cyc !== 3 || inst_valid !== 1'b1) begin
      fails++; $display("FAIL abs3_latency: got %0d cycles valid=%b expected 3 cycles", cyc, inst_valid);
    end
    asserts++;
    if (act !== {16'h8000, 8'hAD, 8'h34, 8'h12, 2'd3}) begin
      fails++; $display("FAIL abs3_inst: got %h expected %h", act, {16'h8000, 8'hAD, 8'h34, 8'h12, 2'd3});
    end
    do_accept();
    mpc = 16'h8003;
    asserts++;
    if (!(mem_req === 1'b1 && mem_addr === mpc)) begin
      fails++; $display("FAIL abs3_next: got req=%b addr=%h expected addr=%h", mem_req, mem_addr, mpc);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    do_redirect(16'hFFFF);
    asserts++;
    if (mem_req !== 1'b0) begin
      fails++; $display("FAIL wrap_req_drop: got %b expected 0", mem_req);
    end
    wait_valid(50, ok);
    asserts++;
    if (!ok || act !== {16'hFFFF, 8'hE8, 8'h00, 8'h00, 2'd1}) begin
      fails++; $display("FAIL wrap_inst: got %h valid=%b expected %h", act, ok, {16'hFFFF, 8'hE8, 8'h00, 8'h00, 2'd1});
    end
    do_accept();
    asserts++;
    if (!(mem_req === 1'b1 && mem_addr === 16'h0000)) begin
      fails++; $display("FAIL wrap_next: got req=%b addr=%h expected addr=0000", mem_req, mem_addr);
    end
  endtask

  task automatic test_stall;
    bit ok;
    logic [41:0] e;
    e = {16'h9000, 8'hA9, 8'h05, 8'h00, 2'd2};
    do_redirect(16'h9000);
    wait_valid(50, ok);
    asserts++;
    if (!ok || act !== e) begin
      fails++; $display("FAIL stall_inst: got %h valid=%b expected %h", act, ok, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      asserts++;
      if (!(inst_valid === 1'b1 && mem_req === 1'b0 && act === e)) begin
        fails++; $display("FAIL stall_hold%0d: got valid=%b req=%b inst=%h expected 1/0/%h", i, inst_valid, mem_req, act, e);
      end
    end
    do_accept();
    asserts++;
    if (!(mem_req === 1'b1 && mem_addr === 16'h9002)) begin
      fails++; $display("FAIL stall_next: got req=%b addr=%h expected addr=9002", mem_req, mem_addr);
    end
  endtask

  task automatic test_redirect_drop;
    bit ok;
    do_redirect(16'hA000);
    wait_addr(16'hA001, 20, ok);
    asserts++;
    if (!ok) begin
      fails++; $display("FAIL redir_reach_op1: got no request at A001 expected one");
    end
    // Redirect lands in the same cycle the operand byte is acked
    do_redirect(16'hC000);
    asserts++;
    if (!(mem_req === 1'b0 && inst_valid === 1'b0)) begin
      fails++; $display("FAIL redir_drop: got req=%b valid=%b expected 0/0", mem_req, inst_valid);
    end
    @(negedge clk);
    asserts++;
    if (!(mem_req === 1'b1 && mem_addr === 16'hC000)) begin
      fails++; $display("FAIL redir_target: got req=%b addr=%h expected addr=C000", mem_req, mem_addr);
    end
    wait_valid(50, ok);
    asserts++;
    if (!ok || act !== {16'hC000, 8'hEA, 8'h00, 8'h00, 2'd1}) begin
      fails++; $display("FAIL redir_inst: got %h valid=%b expected %h", act, ok, {16'hC000, 8'hEA, 8'h00, 8'h00, 2'd1});
    end
    do_accept();
  endtask

  task automatic test_waits;
    logic [15:0] ea;
    waits = 3;
    do_redirect(16'hB000);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ea = 16'hB000 + 16'(k / 4);
      asserts++;
      if (!(mem_req === 1'b1 && mem_addr === ea && inst_valid === 1'b0)) begin
        fails++; $display("FAIL waits_addr%0d: got req=%b addr=%h valid=%b expected 1/%h/0", k, mem_req, mem_addr, inst_valid, ea);
      end
    end
    @(negedge clk);
    asserts++;
    if (!(inst_valid === 1'b1 && act === {16'hB000, 8'hAD, 8'h78, 8'h56, 2'd3})) begin
      fails++; $display("FAIL waits_inst: got valid=%b %h expected %h", inst_valid, act, {16'hB000, 8'hAD, 8'h78, 8'h56, 2'd3});
    end
    waits = 0;
    do_accept();
  endtask

  task automatic test_midreset;
    bit ok;
    do_redirect(16'hA000);
    wait_addr(16'hA001, 20, ok);
    rst_n = 1'b0;
    #1;
    asserts++;
    if (!ok || {mem_req, mem_addr, inst_valid, inst_len, inst_pc} !== {1'b0, 16'h0000, 1'b0, 2'd1, 16'h0000}) begin
      fails++; $display("FAIL midreset_clear: got req=%b addr=%h valid=%b len=%0d pc=%h reached=%b expected 0/0000/0/1/0000",
                        mem_req, mem_addr, inst_valid, inst_len, inst_pc, ok);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_vector_fetch("midreset");
  endtask

  task automatic test_random;
    bit ok;
    logic [15:0] tgt;
    logic [41:0] e;
    for (int a = 16'hD000; a < 16'hD200; a++) mem[a] = 8'($urandom);
    mpc = 16'hD000;
    do_redirect(mpc);
    for (int n = 0; n < 40; n++) begin
      waits = $urandom_range(0, 2);
      wait_valid(100, ok);
      e = exp_inst(mpc);
      asserts++;
      if (!ok || act !== e) begin
        fails++; $display("FAIL rand_inst%0d: got %h valid=%b expected %h", n, act, ok, e);
        break;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        // Redirect together with the handshake: redirect target wins
        tgt = 16'hD000 + 16'($urandom_range(0, 240));
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        inst_ready     = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        mpc = tgt;
        asserts++;
        if (!(mem_req === 1'b0 && inst_valid === 1'b0)) begin
          fails++; $display("FAIL rand_redir%0d: got req=%b valid=%b expected 0/0", n, mem_req, inst_valid);
        end
      end else begin
        do_accept();
        mpc = mpc + 16'(ref_len(mem[mpc]));
        asserts++;
        if (!(mem_req === 1'b1 && mem_addr === mpc)) begin
          fails++; $display("FAIL rand_next%0d: got req=%b addr=%h expected addr=%h", n, mem_req, mem_addr, mpc);
        end
      end
    end
    waits = 0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
    mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
    mem[16'hFFFF] = 8'hE8;
    mem[16'h9000] = 8'hA9; mem[16'h9001] = 8'h05;
    mem[16'hA000] = 8'hAD; mem[16'hA001] = 8'h34; mem[16'hA002] = 8'h12;
    mem[16'hC000] = 8'hEA;
    mem[16'hB000] = 8'hAD; mem[16'hB001] = 8'h78; mem[16'hB002] = 8'h56;
    @(negedge clk);
    test_reset();
    test_abs3();
    test_wrap();
    test_stall();
    test_redirect_drop();
    test_waits();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
